// File: rtl/riscv_fetch_align.sv
// Fetch aligner: word fetches in, one RV32C or RV32 instruction out.
// Six-halfword queue absorbs word-boundary straddles and decode stalls.
module riscv_fetch_align #(
  parameter logic [31:0] PC0 = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_vld,
  input  logic        req_rdy,
  output logic [31:0] req_adr,
  input  logic        rsp_vld,
  input  logic [31:0] rsp_dat,
  input  logic        jmp_vld,
  input  logic [31:0] jmp_adr,
  output logic        ins_vld,
  input  logic        ins_rdy,
  output logic [31:0] ins_dat,
  output logic [31:0] ins_pc,
  output logic        ins_cmp
);

  logic [15:0] hw_buf  [6];
  logic [15:0] buf_nxt [6];
  logic [2:0]  hw_cnt;
  logic [2:0]  cnt_nxt;
  logic [2:0]  pop_n;
  logic [2:0]  push_n;
  logic [2:0]  base;
  logic [2:0]  src;
  logic [1:0]  out_cnt;
  logic [1:0]  dsc_cnt;
  logic [1:0]  kept;
  logic [3:0]  fill;
  logic [31:0] pc_q;
  logic [31:0] fch_adr;
  logic        fch_skp;
  logic        is_cmp;
  logic        req_fire;
  logic        ins_fire;
  logic        keep_rsp;
  logic        unused_ok;

  assign unused_ok = jmp_adr[0];

  always_comb begin
    is_cmp  = hw_buf[0][1:0] != 2'b11;
    ins_vld = !jmp_vld &&
              (is_cmp ? hw_cnt >= 3'd1 : hw_cnt >= 3'd2);
    ins_dat = is_cmp ? {16'h0, hw_buf[0]}
                     : {hw_buf[1], hw_buf[0]};
    ins_cmp = (hw_cnt != 3'd0) && is_cmp;
    ins_pc  = pc_q;
  end

  // A redirect discards everything in flight, so the fill limit is moot.
  always_comb begin
    kept     = out_cnt - dsc_cnt;
    fill     = {1'b0, hw_cnt} + {1'b0, kept, 1'b0};
    req_vld  = rst_n && (out_cnt < 2'd2) &&
               (jmp_vld || fill <= 4'd4);
    req_adr  = jmp_vld ? {jmp_adr[31:2], 2'b00} : fch_adr;
    req_fire = req_vld && req_rdy;
    ins_fire = ins_vld && ins_rdy;
    keep_rsp = rsp_vld && (dsc_cnt == 2'd0) && !jmp_vld;
    pop_n    = ins_fire ? (is_cmp ? 3'd1 : 3'd2) : 3'd0;
    push_n   = keep_rsp ? (fch_skp ? 3'd1 : 3'd2) : 3'd0;
  end

  always_comb begin
    base = hw_cnt - pop_n;
    src  = '0;
    for (int i = 0; i < 6; i++) begin
      src = 3'(i) + pop_n;
      buf_nxt[i] = (src < 3'd6) ? hw_buf[src] : 16'h0;
      if (push_n == 3'd2) begin
        if (3'(i) == base)
          buf_nxt[i] = rsp_dat[15:0];
        if (3'(i) == base + 3'd1)
          buf_nxt[i] = rsp_dat[31:16];
      end else if (push_n == 3'd1) begin
        if (3'(i) == base)
          buf_nxt[i] = rsp_dat[31:16];
      end
    end
    cnt_nxt = jmp_vld ? 3'd0 : hw_cnt + push_n - pop_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++)
        hw_buf[i] <= '0;
      hw_cnt  <= '0;
      out_cnt <= '0;
      dsc_cnt <= '0;
      pc_q    <= PC0;
      fch_adr <= {PC0[31:2], 2'b00};
      fch_skp <= PC0[1];
    end else begin
      for (int i = 0; i < 6; i++)
        hw_buf[i] <= buf_nxt[i];
      hw_cnt  <= cnt_nxt;
      out_cnt <= out_cnt + {1'b0, req_fire} - {1'b0, rsp_vld};
      if (jmp_vld)
        dsc_cnt <= out_cnt - {1'b0, rsp_vld};
      else if (rsp_vld && dsc_cnt != 2'd0)
        dsc_cnt <= dsc_cnt - 2'd1;
      if (req_fire)
        fch_adr <= req_adr + 32'd4;
      else if (jmp_vld)
        fch_adr <= {jmp_adr[31:2], 2'b00};
      if (jmp_vld)
        fch_skp <= jmp_adr[1];
      else if (keep_rsp)
        fch_skp <= 1'b0;
      if (jmp_vld)
        pc_q <= {jmp_adr[31:1], 1'b0};
      else if (ins_fire)
        pc_q <= pc_q + (is_cmp ? 32'd2 : 32'd4);
    end
  end

endmodule

// File: tb/tb_riscv_fetch_align.sv
// Bench for riscv_fetch_align: memory model plus program-order
// instruction reference decoded straight from the memory image.
module tb_riscv_fetch_align;

  localparam logic [31:0] PC0 = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld, req_rdy;
  logic [31:0] req_adr;
  logic        rsp_vld;
  logic [31:0] rsp_dat;
  logic        jmp_vld;
  logic [31:0] jmp_adr;
  logic        ins_vld, ins_rdy, ins_cmp;
  logic [31:0] ins_dat, ins_pc;

  riscv_fetch_align #(.PC0(PC0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_vld(req_vld),
    .req_rdy(req_rdy),
    .req_adr(req_adr),
    .rsp_vld(rsp_vld),
    .rsp_dat(rsp_dat),
    .jmp_vld(jmp_vld),
    .jmp_adr(jmp_adr),
    .ins_vld(ins_vld),
    .ins_rdy(ins_rdy),
    .ins_dat(ins_dat),
    .ins_pc (ins_pc),
    .ins_cmp(ins_cmp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    int          due;
  } rq_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [1024];
  rq_t         q [$];
  int          cyc;
  int          lat;
  bit          lat_rnd;
  int          last_due;
  int          fired;
  logic [31:0] exp_pc;

  logic        s_req_vld, s_req_fire, s_ins_vld, s_ins_fire, s_ins_cmp;
  logic [31:0] s_req_adr, s_ins_dat, s_ins_pc;

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[11:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [15:0] lo;
    logic [31:0] ed;
    bit          is16;
    int          d;
    if (q.size() > 0 && q[0].due <= cyc) begin
      rsp_vld = 1'b1;
      rsp_dat = mem[q[0].adr[11:2]];
    end else begin
      rsp_vld = 1'b0;
      rsp_dat = $urandom;
    end
    #3;
    s_req_vld  = req_vld;
    s_req_adr  = req_adr;
    s_req_fire = req_vld & req_rdy;
    s_ins_vld  = ins_vld;
    s_ins_fire = ins_vld & ins_rdy;
    s_ins_dat  = ins_dat;
    s_ins_pc   = ins_pc;
    s_ins_cmp  = ins_cmp;
    if (jmp_vld)
      chk("ins_vld_in_jmp", ins_vld, 0);
    if (s_req_fire)
      chk("req_adr_align", {30'h0, s_req_adr[1:0]}, 0);
    if (s_req_fire && jmp_vld)
      chk("req_adr_jmp", s_req_adr, {jmp_adr[31:2], 2'b00});
    if (s_ins_fire) begin
      lo   = hw_at(exp_pc);
      is16 = lo[1:0] != 2'b11;
      ed   = is16 ? {16'h0, lo} : {hw_at(exp_pc + 32'd2), lo};
      chk("ins_pc", s_ins_pc, exp_pc);
      chk("ins_dat", s_ins_dat, ed);
      chk("ins_cmp", {31'h0, s_ins_cmp}, {31'h0, is16});
      exp_pc = exp_pc + (is16 ? 32'd2 : 32'd4);
      fired++;
    end
    @(posedge clk);
    if (rsp_vld)
      void'(q.pop_front());
    if (s_req_fire) begin
      d = cyc + (lat_rnd ? int'($urandom_range(1, 4)) : lat);
      if (d <= last_due)
        d = last_due + 1;
      last_due = d;
      q.push_back('{adr: s_req_adr, due: d});
      chk("outstanding_le2", (q.size() <= 2) ? 1 : 0, 1);
    end
    if (jmp_vld)
      exp_pc = {jmp_adr[31:1], 1'b0};
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    jmp_vld = 1'b0;
    req_rdy = 1'b1;
    ins_rdy = 1'b1;
    rsp_vld = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_vld", {31'h0, req_vld}, 0);
    chk("rst_req_adr", req_adr, {PC0[31:2], 2'b00});
    chk("rst_ins_vld", {31'h0, ins_vld}, 0);
    chk("rst_ins_dat", ins_dat, 0);
    chk("rst_ins_pc", ins_pc, PC0);
    chk("rst_ins_cmp", {31'h0, ins_cmp}, 0);
    rst_n    = 1'b1;
    exp_pc   = PC0;
    cyc      = 0;
    last_due = -1;
    fired    = 0;
  endtask

  initial begin
    logic [31:0] e_pc [3];
    logic [31:0] e_dat [3];
    logic [31:0] e_cmp [3];
    logic [31:0] first_req, first_pc;
    bit          got_req, got_ins;
    jmp_vld = 1'b0;
    jmp_adr = '0;
    ins_rdy = 1'b1;
    req_rdy = 1'b1;
    rsp_vld = 1'b0;
    rsp_dat = '0;
    lat     = 1;
    lat_rnd = 1'b0;

    // sequential 32-bit stream, 1-cycle memory
    for (int i = 0; i < 1024; i++)
      mem[i] = 32'h13 | (i << 20) | ((i & 31) << 7);
    do_reset();
    step();
    chk("t1_req_vld_c0", {31'h0, s_req_vld}, 1);
    chk("t1_req_adr_c0", s_req_adr, {PC0[31:2], 2'b00});
    step();
    chk("t1_ins_vld_c1", {31'h0, s_ins_vld}, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t1_ins_vld", {31'h0, s_ins_vld}, 1);
      chk("t1_ins_pc", s_ins_pc, 32'(4 * k));
    end

    // compressed pair
    mem[0] = 32'h0001_0001;
    mem[1] = 32'h0000_0013;
    e_pc  = '{32'd0, 32'd2, 32'd4};
    e_dat = '{32'h1, 32'h1, 32'h13};
    e_cmp = '{32'd1, 32'd1, 32'd0};
    do_reset();
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_ins_vld", {31'h0, s_ins_vld}, 1);
      chk("t2_ins_pc", s_ins_pc, e_pc[k]);
      chk("t2_ins_dat", s_ins_dat, e_dat[k]);
      chk("t2_ins_cmp", {31'h0, s_ins_cmp}, e_cmp[k]);
    end

    // straddle across a word boundary
    mem[0] = 32'h0093_0001;
    mem[1] = 32'h0000_0010;
    do_reset();
    step();
    req_rdy = 1'b0;
    step();
    step();
    chk("t3_c2_vld", {31'h0, s_ins_vld}, 1);
    chk("t3_c2_dat", s_ins_dat, 32'h1);
    req_rdy = 1'b1;
    step();
    chk("t3_c3_vld", {31'h0, s_ins_vld}, 0);
    step();
    chk("t3_c4_vld", {31'h0, s_ins_vld}, 0);
    step();
    chk("t3_c5_vld", {31'h0, s_ins_vld}, 1);
    chk("t3_c5_pc", s_ins_pc, 32'd2);
    chk("t3_c5_dat", s_ins_dat, 32'h0010_0093);
    chk("t3_c5_cmp", {31'h0, s_ins_cmp}, 0);

    // redirect with two requests in flight
    for (int i = 0; i < 1024; i++)
      mem[i] = $urandom;
    mem[32'h40] = 32'h0001_0013;
    lat = 3;
    do_reset();
    step();
    step();
    jmp_vld = 1'b1;
    jmp_adr = 32'h0000_0102;
    step();
    chk("t4_req_vld_jmp", {31'h0, s_req_vld}, 0);
    jmp_vld   = 1'b0;
    got_req   = 1'b0;
    got_ins   = 1'b0;
    first_req = 32'hffff_ffff;
    first_pc  = 32'hffff_ffff;
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_req_fire && !got_req) begin
        got_req   = 1'b1;
        first_req = s_req_adr;
      end
      if (s_ins_fire && !got_ins) begin
        got_ins  = 1'b1;
        first_pc = s_ins_pc;
      end
    end
    chk("t4_first_req", first_req, 32'h100);
    chk("t4_first_pc", first_pc, 32'h102);

    // decode backpressure on a 16-bit stream
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom & 32'hfffc_fffc) | 32'h0001_0001;
    lat = 1;
    do_reset();
    ins_rdy = 1'b0;
    repeat (20) step();
    chk("t5_hw_cnt", {29'h0, dut.hw_cnt}, 6);
    chk("t5_req_vld", {31'h0, s_req_vld}, 0);
    chk("t5_ins_vld", {31'h0, s_ins_vld}, 1);
    ins_rdy = 1'b1;
    fired   = 0;
    repeat (30) step();
    chk("t5_drain", fired, 30);

    // asynchronous reset mid-stream
    chk("t6_pre_vld", {31'h0, ins_vld}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_req_vld", {31'h0, req_vld}, 0);
    chk("t6_ins_vld", {31'h0, ins_vld}, 0);
    chk("t6_ins_pc", ins_pc, PC0);
    chk("t6_ins_dat", ins_dat, 0);
    chk("t6_ins_cmp", {31'h0, ins_cmp}, 0);
    chk("t6_req_adr", req_adr, {PC0[31:2], 2'b00});
    do_reset();
    step();
    chk("t6_post_vld", {31'h0, s_req_vld}, 1);
    chk("t6_post_adr", s_req_adr, {PC0[31:2], 2'b00});

    // random traffic, latency, stalls and redirects
    for (int i = 0; i < 1024; i++)
      mem[i] = $urandom;
    lat_rnd = 1'b1;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500)
        do_reset();
      ins_rdy = $urandom_range(0, 9) < 7;
      req_rdy = $urandom_range(0, 9) < 7;
      jmp_vld = ($urandom_range(0, 29) == 0) ||
                (jmp_vld && $urandom_range(0, 1) == 1);
      jmp_adr = $urandom;
      step();
    end
    chk("rand_live", (fired > 200) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
